// File: rtl/tm1638_key_reader.sv
// rtl/tm1638_key_reader.sv - TM1638 key-scan read engine (command out, 32 key bits in).
// Optional TM1638_KEY_CHANGE_EN adds o_Changed, flagging a result that differs from the last one.
module tm1638_key_reader #(
    parameter int          CYCLES      = 1,
    parameter int          WAIT_CYCLES = 32,
    parameter logic [7:0]  CMD         = 8'h42
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    output logic        o_Busy,
    output logic        o_Valid,
    output logic [31:0] o_Keys,
`ifdef TM1638_KEY_CHANGE_EN
    output logic        o_Changed,
`endif
    output logic        o_SPI_Stb,
    output logic        o_SPI_Clk,
    output logic        o_SPI_Dio_Out,
    output logic        o_SPI_Dio_Oe,
    input  logic        i_SPI_Dio
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] LOAD     = 4'd1;
    localparam logic [3:0] CMD_LOW  = 4'd2;
    localparam logic [3:0] CMD_HIGH = 4'd3;
    localparam logic [3:0] WAIT     = 4'd4;
    localparam logic [3:0] RX_LOW   = 4'd5;
    localparam logic [3:0] RX_HIGH  = 4'd6;
    localparam logic [3:0] PAUSE    = 4'd7;
    localparam logic [3:0] DONE     = 4'd8;

    localparam logic [15:0] PHASE_LAST = 16'(CYCLES);
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_CYCLES - 1);

    logic [3:0]  state;
    logic [15:0] phase_cnt;
    logic [15:0] wait_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [31:0] keys;
    logic        dio_meta;
    logic        dio_sync;
    logic        phase_last;
    logic        wait_last;
`ifdef TM1638_KEY_CHANGE_EN
    logic        changed;
`endif

    assign phase_last = (phase_cnt == PHASE_LAST);
    assign wait_last  = (wait_cnt == WAIT_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            keys      <= '0;
            dio_meta  <= 1'b0;
            dio_sync  <= 1'b0;
`ifdef TM1638_KEY_CHANGE_EN
            changed   <= 1'b0;
`endif
        end else begin
            // DIO is driven by the device off our clock domain
            dio_meta <= i_SPI_Dio;
            dio_sync <= dio_meta;
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    phase_cnt <= '0;
                    wait_cnt  <= '0;
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    state     <= CMD_LOW;
                end
                CMD_LOW: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        state     <= CMD_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                CMD_HIGH: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= CMD_LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                WAIT: begin
                    if (wait_last) begin
                        wait_cnt <= '0;
                        state    <= RX_LOW;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RX_LOW: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        state     <= RX_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                RX_HIGH: begin
                    if (phase_last) begin
                        // Sample just before the falling edge, when the device bit is most settled
                        shift_reg[bit_cnt] <= dio_sync;
                        phase_cnt          <= '0;
                        if (bit_cnt == 5'd31) begin
                            state <= PAUSE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= RX_LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                PAUSE: begin
                    if (phase_last) begin
                        keys  <= shift_reg;
`ifdef TM1638_KEY_CHANGE_EN
                        changed <= (shift_reg != keys);
`endif
                        phase_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_Busy        = (state != IDLE);
        o_Valid       = (state == DONE);
        o_SPI_Stb     = 1'b1;
        o_SPI_Clk     = 1'b1;
        o_SPI_Dio_Out = 1'b0;
        o_SPI_Dio_Oe  = 1'b0;
        case (state)
            CMD_LOW: begin
                o_SPI_Stb     = 1'b0;
                o_SPI_Clk     = 1'b0;
                o_SPI_Dio_Out = CMD[bit_cnt[2:0]];
                o_SPI_Dio_Oe  = 1'b1;
            end
            CMD_HIGH: begin
                o_SPI_Stb     = 1'b0;
                o_SPI_Dio_Out = CMD[bit_cnt[2:0]];
                o_SPI_Dio_Oe  = 1'b1;
            end
            WAIT, RX_HIGH: begin
                o_SPI_Stb = 1'b0;
            end
            RX_LOW: begin
                o_SPI_Stb = 1'b0;
                o_SPI_Clk = 1'b0;
            end
            default: begin
                o_SPI_Stb = 1'b1;
            end
        endcase
    end

    assign o_Keys = keys;
`ifdef TM1638_KEY_CHANGE_EN
    assign o_Changed = (state == DONE) && changed;
`endif

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb/tb_tm1638_key_reader.sv - directed bench for tm1638_key_reader with a serial key-scan device model.
module tb_tm1638_key_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        dio1 = 1'b0;
    logic        dio3 = 1'b0;
    logic        busy1, valid1, stb1, sclk1, dout1, oe1;
    logic        busy3, valid3, stb3, sclk3, dout3, oe3;
    logic [31:0] keys1, keys3;
    logic        chg1, chg3;
    logic [31:0] dev_data1 = '0;
    logic [31:0] dev_data3 = '0;
    int          idx1 = 0;
    int          idx3 = 0;
    int          vt1 = 0;
    int          checks = 0;
    int          errors = 0;
    logic        sel = 1'b0;

    logic        m_busy, m_valid, m_stb, m_sclk, m_dout, m_oe, m_chg;
    logic [31:0] m_keys;

    int          t_busy, t_valid, t_rx, t_wait, t_cmd_low, t_rx_low, t_rx_high, t_oe_bad, t_guard;
    logic [7:0]  t_cmd;
    logic [31:0] t_keys;
    logic        t_chg;

    always #5 clk = ~clk;

    tm1638_key_reader #(.CYCLES(1), .WAIT_CYCLES(4), .CMD(8'h42)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start1), .o_Busy(busy1), .o_Valid(valid1),
        .o_Keys(keys1),
`ifdef TM1638_KEY_CHANGE_EN
        .o_Changed(chg1),
`endif
        .o_SPI_Stb(stb1), .o_SPI_Clk(sclk1), .o_SPI_Dio_Out(dout1), .o_SPI_Dio_Oe(oe1),
        .i_SPI_Dio(dio1)
    );

    tm1638_key_reader #(.CYCLES(3), .WAIT_CYCLES(5), .CMD(8'h42)) dut3 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start3), .o_Busy(busy3), .o_Valid(valid3),
        .o_Keys(keys3),
`ifdef TM1638_KEY_CHANGE_EN
        .o_Changed(chg3),
`endif
        .o_SPI_Stb(stb3), .o_SPI_Clk(sclk3), .o_SPI_Dio_Out(dout3), .o_SPI_Dio_Oe(oe3),
        .i_SPI_Dio(dio3)
    );

`ifndef TM1638_KEY_CHANGE_EN
    assign chg1 = 1'b0;
    assign chg3 = 1'b0;
`endif

    assign m_busy  = sel ? busy3  : busy1;
    assign m_valid = sel ? valid3 : valid1;
    assign m_keys  = sel ? keys3  : keys1;
    assign m_stb   = sel ? stb3   : stb1;
    assign m_sclk  = sel ? sclk3  : sclk1;
    assign m_dout  = sel ? dout3  : dout1;
    assign m_oe    = sel ? oe3    : oe1;
    assign m_chg   = sel ? chg3   : chg1;

    // Device model: presents the next key bit on each read-phase falling edge
    always @(negedge sclk1) begin
        if (!stb1 && !oe1 && idx1 < 32) begin
            dio1 = dev_data1[idx1];
            idx1 = idx1 + 1;
        end
    end
    always @(posedge stb1) idx1 = 0;

    always @(negedge sclk3) begin
        if (!stb3 && !oe3 && idx3 < 32) begin
            dio3 = dev_data3[idx3];
            idx3 = idx3 + 1;
        end
    end
    always @(posedge stb3) idx3 = 0;

    always @(negedge clk) if (valid1) vt1 = vt1 + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on the first negedge where busy is high; returns on the first idle negedge
    task automatic run_txn();
        logic prev_clk;
        int   ncmd;
        prev_clk = 1'b1;
        ncmd = 0;
        t_busy = 0; t_valid = 0; t_rx = 0; t_wait = 0; t_cmd_low = 0;
        t_rx_low = 0; t_rx_high = 0; t_oe_bad = 0; t_guard = 0;
        t_cmd = '0; t_keys = '0; t_chg = 1'b0;
        while (m_busy && t_guard < 2000) begin
            t_busy = t_busy + 1;
            if (m_valid) begin
                t_valid = t_valid + 1;
                t_keys  = m_keys;
                t_chg   = m_chg;
            end
            if (m_sclk && !prev_clk) begin
                if (m_oe && ncmd < 8) begin
                    t_cmd[ncmd] = m_dout;
                    ncmd = ncmd + 1;
                end else if (!m_oe) begin
                    t_rx = t_rx + 1;
                end
            end
            if (m_oe && (t_rx > 0 || t_wait > 0)) t_oe_bad = t_oe_bad + 1;
            if (!m_sclk && m_oe && ncmd == 0) t_cmd_low = t_cmd_low + 1;
            if (!m_stb && m_sclk && !m_oe && t_rx == 0) t_wait = t_wait + 1;
            if (!m_sclk && !m_oe && t_rx == 0) t_rx_low = t_rx_low + 1;
            if (!m_stb && m_sclk && !m_oe && t_rx == 1) t_rx_high = t_rx_high + 1;
            prev_clk = m_sclk;
            @(negedge clk);
            t_guard = t_guard + 1;
        end
        check("txn_timeout", 32'(t_guard < 2000), 32'd1);
    endtask

    initial begin
        int gap;
        int vbefore;
        int wguard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_keys", keys1, 32'd0);
        check("rst_stb", 32'(stb1), 32'd1);
        check("rst_clk", 32'(sclk1), 32'd1);
        check("rst_dout", 32'(dout1), 32'd0);
        check("rst_oe", 32'(oe1), 32'd0);

        // Command framing, busy length and first key word
        sel = 1'b0;
        dev_data1 = 32'h3C8001A5;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        run_txn();
        check("t1_busy", 32'(t_busy), 32'd168);
        check("t1_cmd", 32'(t_cmd), 32'h42);
        check("t1_cmd_low", 32'(t_cmd_low), 32'd2);
        check("t1_wait", 32'(t_wait), 32'd4);
        check("t1_rx_edges", 32'(t_rx), 32'd32);
        check("t1_oe_late", 32'(t_oe_bad), 32'd0);
        check("t2_valid_cnt", 32'(t_valid), 32'd1);
        check("t2_keys_at_valid", t_keys, 32'h3C8001A5);
        check("t2_keys_hold", keys1, 32'h3C8001A5);

        // Start held high: back-to-back with one idle cycle between
        dev_data1 = 32'hFFFF0000;
        start1 = 1'b1;
        @(negedge clk);
        run_txn();
        check("t3a_busy", 32'(t_busy), 32'd168);
        check("t3a_keys", t_keys, 32'hFFFF0000);
        check("t3_idle_stb", 32'(stb1), 32'd1);
        dev_data1 = 32'h5A5A5A5A;
        gap = 0;
        while (!busy1 && gap < 10) begin
            gap = gap + 1;
            @(negedge clk);
        end
        check("t3_gap", 32'(gap), 32'd1);
        start1 = 1'b0;
        run_txn();
        check("t3b_busy", 32'(t_busy), 32'd168);
        check("t3b_valid_cnt", 32'(t_valid), 32'd1);
        check("t3b_keys", t_keys, 32'h5A5A5A5A);

        // Reset in the middle of receive bit 10
        dev_data1 = 32'h0000FFFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wguard = 0;
        while (idx1 < 11 && wguard < 1000) begin
            wguard = wguard + 1;
            @(negedge clk);
        end
        check("t4_reach_bit10", 32'(wguard < 1000), 32'd1);
        vbefore = vt1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_stb", 32'(stb1), 32'd1);
        check("t4_clk", 32'(sclk1), 32'd1);
        check("t4_oe", 32'(oe1), 32'd0);
        check("t4_busy", 32'(busy1), 32'd0);
        check("t4_keys", keys1, 32'd0);
        repeat (200) @(negedge clk);
        check("t4_no_valid", 32'(vt1 - vbefore), 32'd0);
        dev_data1 = 32'hFFFFFFFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        run_txn();
        check("t4_resume_busy", 32'(t_busy), 32'd168);
        check("t4_resume_keys", t_keys, 32'hFFFFFFFF);

`ifdef TM1638_KEY_CHANGE_EN
        dev_data1 = 32'h00000010;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        run_txn();
        check("t5_chg_first", 32'(t_chg), 32'd1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        run_txn();
        check("t5_chg_same", 32'(t_chg), 32'd0);
        check("t5_keys", t_keys, 32'h00000010);
`endif

        // Slower clock: 4-cycle phases, 5-cycle wait gap
        sel = 1'b1;
        dev_data3 = 32'h80000001;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        run_txn();
        check("t6_busy", 32'(t_busy), 32'd331);
        check("t6_cmd", 32'(t_cmd), 32'h42);
        check("t6_cmd_low", 32'(t_cmd_low), 32'd4);
        check("t6_wait", 32'(t_wait), 32'd5);
        check("t6_rx_low", 32'(t_rx_low), 32'd4);
        check("t6_rx_high", 32'(t_rx_high), 32'd4);
        check("t6_rx_edges", 32'(t_rx), 32'd32);
        check("t6_keys", t_keys, 32'h80000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
